// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multi-cycle MIPS: sequences each instruction and drives
// the datapath enables/selects, plus a retired-instruction counter and illegal-op flag.
module multicycle_main_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  output logic             pcwrite,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             branch,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [1:0]       aluop,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  // Bundle order: pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord,
  // memtoreg, regdst, alusrcb[1:0], pcsrc[1:0], aluop[1:0]
  function automatic logic [14:0] ctrl_of(input logic [3:0] s);
    logic [14:0] c;
    c = 15'd0;
    case (s)
      S_FETCH:   c = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
      S_DECODE:  c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00};
      S_MEMADR:  c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00};
      S_MEMRD:   c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
      S_MEMWB:   c = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
      S_MEMWR:   c = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
      S_EXECUTE: c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10};
      S_ALUWB:   c = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00};
      S_BRANCH:  c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01};
      S_ADDIEX:  c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00};
      S_ADDIWB:  c = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
      S_JUMP:    c = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00};
      default:   c = 15'd0;
    endcase
    return c;
  endfunction

  logic [3:0]       state_r;
  logic [3:0]       next_state_s;
  logic             illegal_s;
  logic             terminal_s;
  logic [14:0]      ctrl_s;
  logic [14:0]      ctrl_r;
  logic             illegal_r;
  logic [CNT_W-1:0] retired_r;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic and illegal-opcode / retire detection
  always_comb begin
    next_state_s = S_FETCH;
    illegal_s    = 1'b0;
    terminal_s   = 1'b0;
    case (state_r)
      S_FETCH:   next_state_s = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_RTYP:      next_state_s = S_EXECUTE;
          OP_BEQ:       next_state_s = S_BRANCH;
          OP_ADDI:      next_state_s = S_ADDIEX;
          OP_J:         next_state_s = S_JUMP;
          default: begin
            next_state_s = S_FETCH;
            illegal_s    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (op == OP_SW) begin
          next_state_s = S_MEMWR;
        end else begin
          next_state_s = S_MEMRD;
        end
      end
      S_MEMRD:   next_state_s = S_MEMWB;
      S_EXECUTE: next_state_s = S_ALUWB;
      S_ADDIEX:  next_state_s = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        next_state_s = S_FETCH;
        terminal_s   = 1'b1;
      end
      default:   next_state_s = S_FETCH;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs track state
  always_comb begin
    ctrl_s = ctrl_of(next_state_s);
  end

  // Registered control outputs, illegal-op pulse and retired counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_r    <= ctrl_of(S_FETCH);
      illegal_r <= 1'b0;
      retired_r <= {CNT_W{1'b0}};
    end else begin
      ctrl_r    <= ctrl_s;
      illegal_r <= illegal_s;
      if (terminal_s) begin
        retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  assign {pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord,
          memtoreg, regdst, alusrcb, pcsrc, aluop} = ctrl_r;
  assign state      = state_r;
  assign illegal_op = illegal_r;
  assign retired    = retired_r;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm: instruction-level reference model
// pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_multicycle_main_fsm;

  localparam int CW = 4;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RTYP = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    op;
  logic          pcwrite, memwrite, irwrite, regwrite, alusrca, branch;
  logic          iord, memtoreg, regdst, illegal_op;
  logic [1:0]    alusrcb, pcsrc, aluop;
  logic [3:0]    state;
  logic [CW-1:0] retired;

  multicycle_main_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .op(op),
    .pcwrite(pcwrite), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .branch(branch), .iord(iord), .memtoreg(memtoreg),
    .regdst(regdst), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .state(state), .illegal_op(illegal_op), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    st;
    logic [14:0]   ctrl;
    logic          ill;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  int   model_ret = 0;
  bit   pend_ill = 1'b0;

  function automatic bit is_legal(input logic [5:0] o);
    return (o == LW) || (o == SW) || (o == RTYP) || (o == BEQ) || (o == ADDI) || (o == JMP);
  endfunction

  // Cycles per instruction, counted from FETCH
  function automatic int n_cycles(input logic [5:0] o);
    case (o)
      LW:         return 5;
      SW, RTYP, ADDI: return 4;
      BEQ, JMP:   return 3;
      default:    return 2;
    endcase
  endfunction

  // State visited in cycle i of an instruction with opcode o
  function automatic logic [3:0] st_at(input logic [5:0] o, input int i);
    logic [3:0] s;
    if (i == 0) s = 4'd0;
    else if (i == 1) s = 4'd1;
    else begin
      case (o)
        LW:      s = (i == 2) ? 4'd2 : ((i == 3) ? 4'd3 : 4'd4);
        SW:      s = (i == 2) ? 4'd2 : 4'd5;
        RTYP:    s = (i == 2) ? 4'd6 : 4'd7;
        ADDI:    s = (i == 2) ? 4'd9 : 4'd10;
        BEQ:     s = 4'd8;
        JMP:     s = 4'd11;
        default: s = 4'd0;
      endcase
    end
    return s;
  endfunction

  // Expected control bundle from the per-state output table
  function automatic logic [14:0] exp_ctrl(input logic [3:0] s);
    logic pcw, mw, irw, rw, asa, br, io, m2r, rd;
    logic [1:0] asb, pcs, aop;
    pcw = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; asa = 1'b0; br = 1'b0;
    io = 1'b0; m2r = 1'b0; rd = 1'b0; asb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (s)
      4'd0:  begin irw = 1'b1; pcw = 1'b1; asb = 2'b01; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  io = 1'b1;
      4'd4:  begin m2r = 1'b1; rw = 1'b1; end
      4'd5:  begin io = 1'b1; mw = 1'b1; end
      4'd6:  begin asa = 1'b1; aop = 2'b10; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; br = 1'b1; end
      4'd9:  begin asa = 1'b1; asb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin pcs = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    return {pcw, mw, irw, rw, asa, br, io, m2r, rd, asb, pcs, aop};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drives one instruction; op carries junk in cycles where it must be ignored
  task automatic run_instr(input logic [5:0] o, input bit skip_fetch);
    int n;
    n = n_cycles(o);
    for (int i = (skip_fetch ? 1 : 0); i < n; i++) begin
      exp_t e;
      if (i == 1 || (i == 2 && (o == LW || o == SW))) op = o;
      else op = 6'($urandom);
      e.st   = st_at(o, i);
      e.ctrl = exp_ctrl(e.st);
      e.ill  = (i == 0) && pend_ill;
      e.ret  = CW'(model_ret);
      q.push_back(e);
      if (i == 0) pend_ill = 1'b0;
      @(posedge clk); #1;
    end
    if (is_legal(o)) model_ret = (model_ret + 1) % (1 << CW);
    else pend_ill = 1'b1;
  endtask

  task automatic run_random(input int count);
    logic [5:0] legal_ops [6];
    legal_ops = '{LW, SW, RTYP, BEQ, ADDI, JMP};
    for (int k = 0; k < count; k++) begin
      int r;
      r = $urandom_range(0, 7);
      if (r < 6) run_instr(legal_ops[r], 1'b0);
      else run_instr(6'($urandom), 1'b0);
    end
  endtask

  // Monitor: every cycle presents a full output set, compared against the queue head
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t a;
      exp_t e;
      a.st   = state;
      a.ctrl = {pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord,
                memtoreg, regdst, alusrcb, pcsrc, aluop};
      a.ill  = illegal_op;
      a.ret  = retired;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_underflow t=%0t actual_state=%0d", $time, state);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          fails++;
          $display("FAIL cycle t=%0t actual st=%0d ctrl=%b ill=%b ret=%0d required st=%0d ctrl=%b ill=%b ret=%0d",
                   $time, a.st, a.ctrl, a.ill, a.ret, e.st, e.ctrl, e.ill, e.ret);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    op    = 6'd0;
    #8;
    chk("reset_state",   32'(state), 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    chk("reset_illegal", 32'(illegal_op), 32'd0);
    chk("reset_fetch_ctrl",
        32'({pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord,
             memtoreg, regdst, alusrcb, pcsrc, aluop}), 32'(exp_ctrl(4'd0)));
    #4;
    reset = 1'b1;
    op    = LW;
    @(posedge clk); #1;
    mon_en = 1'b1;
    run_instr(LW, 1'b1);
    run_instr(SW, 1'b0);
    run_instr(RTYP, 1'b0);
    run_instr(ADDI, 1'b0);
    run_instr(BEQ, 1'b0);
    run_instr(JMP, 1'b0);
    run_instr(6'b111111, 1'b0);
    run_instr(SW, 1'b0);
    run_random(45);

    // Async reset in MEMRD of a lw
    op = LW;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.st   = st_at(LW, i);
      e.ctrl = exp_ctrl(e.st);
      e.ill  = (i == 0) && pend_ill;
      e.ret  = CW'(model_ret);
      q.push_back(e);
      if (i == 0) pend_ill = 1'b0;
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    chk("pre_reset_in_memrd", 32'(state), 32'd3);
    reset = 1'b0;
    #1;
    chk("async_reset_state",    32'(state), 32'd0);
    chk("async_reset_retired",  32'(retired), 32'd0);
    chk("async_reset_regwrite", 32'(regwrite), 32'd0);
    chk("async_reset_illegal",  32'(illegal_op), 32'd0);
    #1;
    reset     = 1'b1;
    model_ret = 0;
    pend_ill  = 1'b0;
    mon_en    = 1'b1;
    run_instr(6'b110011, 1'b0);
    run_instr(LW, 1'b0);
    run_random(12);
    mon_en = 1'b0;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Main control state machine for the multi-cycle MIPS processor. It sits inside the controller, directly upstream of the datapath.
- It takes the 6-bit opcode from the instruction register and sequences every instruction through fetch, decode, execute, memory and writeback. It drives all datapath enables and mux selects.
- It also keeps a retired-instruction counter and flags illegal opcodes, for the bench's pass/fail checks.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- op  input  6  opcode field instr[31:26] from the instruction register
- pcwrite  output  1  unconditional PC write enable
- memwrite  output  1  unified memory write enable
- irwrite  output  1  instruction register write enable
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A select: 0 = PC, 1 = register A
- branch  output  1  conditional PC write; gated with zero outside this block
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memtoreg  output  1  writeback select: 1 = data register
- regdst  output  1  destination select: 1 = rd, 0 = rt
- alusrcb  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2
- pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- aluop  output  2  00 = add, 01 = subtract, 10 = decode funct
- state  output  4  current state encoding, for debug
- illegal_op  output  1  one-cycle pulse on an unrecognised opcode
- retired  output  CNT_W  count of completed instructions

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12-15 are unused.
- Reset (reset=0, asynchronous): state=FETCH, retired=0, illegal_op=0.
  - Control outputs are Moore-decoded from state, so while in reset they show FETCH values.
  - Deassertion is sampled on the next rising edge.
- Transitions, taken on each rising edge:
  - FETCH -> DECODE.
  - DECODE by op:
    - 100011 (lw) and 101011 (sw) -> MEMADR.
    - 000000 (R-type) -> EXECUTE.
    - 000100 (beq) -> BRANCH.
    - 001000 (addi) -> ADDIEX.
    - 000010 (j) -> JUMP.
    - Any other op -> FETCH, with illegal_op=1 for exactly the following cycle.
  - MEMADR: lw -> MEMRD, sw -> MEMWR, using the op value sampled in that cycle.
  - MEMRD -> MEMWB.
  - EXECUTE -> ALUWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
  - Unused encodings -> FETCH. They do not count as retired and do not raise illegal_op.
- Control outputs per state (every signal not listed is 0):
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, aluop=10.
  - ALUWB: regdst=1, regwrite=1.
  - BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- Cycles per instruction, counted from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- retired increments by 1 on every edge that leaves a terminal state (MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP).
  - It wraps modulo 2^CNT_W.
  - It does not increment for illegal opcodes.
- op is only evaluated in DECODE and MEMADR; its value in other states is ignored.
- Reset asserted mid-instruction returns immediately to FETCH and clears retired. A pending illegal_op pulse is cancelled.
- memwrite is asserted only in MEMWR. No two of pcwrite, memwrite and regwrite are ever 1 together, except pcwrite with irwrite in FETCH.

Test Plan:
- Hold reset=0 for 12 ns, then release -> state=0, retired=0, irwrite=1, pcwrite=1, alusrcb=01 before release; state=1 on the first edge after release.
- Apply op=100011 (lw) -> state sequence 0,1,2,3,4,0; memtoreg=1 and regwrite=1 only in state 4; retired=1 after 5 cycles.
- Apply op=101011 (sw) -> state sequence 0,1,2,5,0; memwrite=1 and iord=1 in state 5 only; retired increments once.
- Run op sequence 000000, 001000, 000100, 000010 -> 4+4+3+3 = 14 cycles; retired=4; aluop=10 in EXECUTE; pcsrc=01 with branch=1 in BRANCH; pcsrc=10 with pcwrite=1 in JUMP.
- Apply op=111111 -> state sequence 0,1,0; illegal_op=1 for exactly one cycle; retired unchanged.
- Pull reset low asynchronously during MEMRD of a lw -> state=0 and retired=0 before the next edge; no regwrite pulse occurs.
